// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel stream that feeds the convolution stage.
package pixel_pkg;

   localparam int unsigned PIX_WORD_SIZE = 8;
   localparam int unsigned PIX_ROW_SIZE  = 540;
   localparam int unsigned PIX_NUM_ROWS  = 540;

   typedef logic [PIX_WORD_SIZE-1:0] pixel_t;

   typedef struct packed {
      pixel_t pixel;
      logic   sof;
      logic   eol;
      logic   eof;
   } beat_t;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} streamer_state_t;

   // Counter/address width that stays at least one bit for degenerate sizes.
   function automatic int unsigned min1_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry skid FIFO; the head lives in slot0 so consumers see register outputs only.
module stream_skid_fifo
   import pixel_pkg::*;
#(
   parameter type beat_type_t = beat_t
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  beat_type_t data_i,
   input  logic       pop_i,
   output beat_type_t head_o,
   output logic [1:0] occ_o,
   output logic       full_o,
   output logic       empty_o
);

   beat_type_t slot0_q, slot0_d;
   beat_type_t slot1_q, slot1_d;
   logic       v0_q, v0_d;
   logic       v1_q, v1_d;

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      v0_d    = v0_q;
      v1_d    = v1_q;
      if (pop_i) begin
         if (v1_q) begin
            slot0_d = slot1_q;
            v1_d    = 1'b0;
         end else begin
            v0_d = 1'b0;
         end
      end
      // Push lands in whichever slot is free after the pop has been applied.
      if (push_i) begin
         if (!v0_d) begin
            slot0_d = data_i;
            v0_d    = 1'b1;
         end else begin
            slot1_d = data_i;
            v1_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         slot0_q <= '0;
         slot1_q <= '0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         v0_q    <= v0_d;
         v1_q    <= v1_d;
      end
   end

   assign head_o  = slot0_q;
   assign occ_o   = {1'b0, v0_q} + {1'b0, v1_q};
   assign full_o  = v1_q;
   assign empty_o = ~v0_q;

   assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !pop_i));
   assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/frame_streamer.sv
// Reads one raster frame from a 1-cycle-latency memory and streams it out with
// sof/eol/eof flags over valid/ready at full throughput.
module frame_streamer
   import pixel_pkg::*;
#(
   parameter int unsigned WORD_SIZE = PIX_WORD_SIZE,
   parameter int unsigned ROW_SIZE  = PIX_ROW_SIZE,
   parameter int unsigned NUM_ROWS  = PIX_NUM_ROWS,
   parameter int unsigned ADDR_W    = min1_clog2(ROW_SIZE * NUM_ROWS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 rd_en,
   output logic [ADDR_W-1:0]    rd_addr,
   input  logic [WORD_SIZE-1:0] rd_data,
   output logic [WORD_SIZE-1:0] outputPixel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sof,
   output logic                 eol,
   output logic                 eof
);

   localparam int unsigned NUM_PIX = ROW_SIZE * NUM_ROWS;
   localparam int unsigned COL_W   = min1_clog2(ROW_SIZE);
   localparam int unsigned ROW_W   = min1_clog2(NUM_ROWS);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
   localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(ROW_SIZE - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);

   typedef struct packed {
      logic [WORD_SIZE-1:0] pixel;
      logic                 sof;
      logic                 eol;
      logic                 eof;
   } stream_beat_t;

   streamer_state_t   state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              inflight_q, inflight_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;

   stream_beat_t push_beat;
   stream_beat_t head;
   logic         push;
   logic         pop;
   logic         fifo_full;
   logic         fifo_empty;
   logic [1:0]   fifo_occ;
   logic         rd_issue;
   logic [2:0]   credit_used;
   logic [2:0]   credit_limit;

   assign pop  = ~fifo_empty & out_ready;
   assign push = inflight_q;

   // Reads are allowed only while the FIFO plus in-flight data can still fit after this pop.
   assign credit_used  = {1'b0, fifo_occ} + {2'b0, inflight_q};
   assign credit_limit = 3'd2 + {2'b0, pop};

   always_comb begin
      rd_issue = 1'b0;
      if (state_q == FETCH) begin
         rd_issue = (credit_used < credit_limit);
      end
   end

   always_comb begin
      push_beat.pixel = rd_data;
      push_beat.sof   = (col_q == '0) && (row_q == '0);
      push_beat.eol   = (col_q == LAST_COL);
      push_beat.eof   = (col_q == LAST_COL) && (row_q == LAST_ROW);
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (push) begin
         if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      inflight_d = rd_issue;
      if (rd_issue) begin
         addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (rd_issue && (addr_q == LAST_ADDR)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head.eof) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         col_q      <= col_d;
         row_q      <= row_d;
      end
   end

   stream_skid_fifo #(
      .beat_type_t(stream_beat_t)
   ) u_fifo (
      .clk_i  (clk),
      .rst_ni (rst),
      .push_i (push),
      .data_i (push_beat),
      .pop_i  (pop),
      .head_o (head),
      .occ_o  (fifo_occ),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   assign busy        = busy_q;
   assign done        = done_q;
   assign rd_en       = rd_issue;
   assign rd_addr     = addr_q;
   assign out_valid   = ~fifo_empty;
   assign outputPixel = head.pixel;
   assign sof         = head.sof;
   assign eol         = head.eol;
   assign eof         = head.eof;

   assert property (@(posedge clk) disable iff (!rst) !(rd_issue && fifo_full && !pop));

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer: a 4x3 frame instance and a 1x1 instance.
module tb_frame_streamer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic       rd_en;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] out_pix;
   logic       out_valid;
   logic       sof;
   logic       eol;
   logic       eof;

   logic       start1;
   logic       ready1;
   logic       busy1;
   logic       done1;
   logic       rd_en1;
   logic [0:0] rd_addr1;
   logic [7:0] rd_data1;
   logic [7:0] pix1;
   logic       valid1;
   logic       sof1;
   logic       eol1;
   logic       eof1;

   int total;
   int bad;

   logic [7:0] cap_pix[$];
   logic [2:0] cap_flg[$];
   int         cap_cyc[$];
   int         done_n;
   int         done_cyc;
   int         stall_bad;
   int         occ_bad;
   int         addr_bad;
   int         win_reads;
   logic       c1_busy;
   logic       c1_rd_en;
   logic [3:0] c1_addr;
   logic       done_busy;
   logic       post_busy;
   logic [18:0] snap_rst;
   logic [9:0]  snap_stall;

   frame_streamer #(
      .WORD_SIZE(8),
      .ROW_SIZE (4),
      .NUM_ROWS (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .outputPixel(out_pix),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sof        (sof),
      .eol        (eol),
      .eof        (eof)
   );

   frame_streamer #(
      .WORD_SIZE(8),
      .ROW_SIZE (1),
      .NUM_ROWS (1)
   ) dut1 (
      .clk        (clk),
      .rst        (rst),
      .start      (start1),
      .busy       (busy1),
      .done       (done1),
      .rd_en      (rd_en1),
      .rd_addr    (rd_addr1),
      .rd_data    (rd_data1),
      .outputPixel(pix1),
      .out_valid  (valid1),
      .out_ready  (ready1),
      .sof        (sof1),
      .eol        (eol1),
      .eof        (eof1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame memories: memory[i] = i for the 4x3 frame, memory[0] = 0xA5 for the 1x1 frame.
   always @(posedge clk) begin
      if (rd_en) rd_data <= 8'(rd_addr);
      if (rd_en1) rd_data1 <= (rd_addr1 == 1'b0) ? 8'hA5 : 8'h00;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one frame request on the 4x3 instance and records what the stream did.
   // mode 0: ready high; 1: ready 1,0,0,1 repeating; 2: ready low through cycle 20.
   task automatic run_frame(input int mode, input bit pulses, input int rst_at);
      int         occ_m;
      logic       prev_rd;
      logic       prev_stall;
      logic [10:0] prev_beat;
      int         exp_addr;
      bit         fin;
      cap_pix.delete();
      cap_flg.delete();
      cap_cyc.delete();
      done_n = 0; done_cyc = -1; stall_bad = 0; occ_bad = 0; addr_bad = 0; win_reads = 0;
      occ_m = 0; prev_rd = 1'b0; prev_stall = 1'b0; prev_beat = '0; exp_addr = 0; fin = 1'b0;
      c1_busy = 1'b0; c1_rd_en = 1'b0; c1_addr = '1; done_busy = 1'b0; post_busy = 1'b1;
      snap_rst = '1; snap_stall = '0;
      for (int c = 0; c < 300 && !fin; c++) begin
         start = (c == 0) || (pulses && (c == 5 || c == 8));
         case (mode)
            1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
            2:       out_ready = (c > 20);
            default: out_ready = 1'b1;
         endcase
         rst = (c != rst_at);
         @(negedge clk);
         if (!rst) begin
            occ_m = 0;
            prev_rd = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (c == 1) begin
               c1_busy = busy; c1_rd_en = rd_en; c1_addr = rd_addr;
            end
            if (rst_at >= 0 && c == rst_at + 1)
               snap_rst = {busy, done, rd_en, out_valid, sof, eol, eof, rd_addr, out_pix};
            if (c == 20) snap_stall = {out_valid, out_pix, sof};
            if (prev_stall && (!out_valid || {out_pix, sof, eol, eof} != prev_beat))
               stall_bad++;
            if (out_valid !== (occ_m != 0)) occ_bad++;
            if (rd_en) begin
               if (rd_addr !== 4'(exp_addr)) addr_bad++;
               exp_addr++;
               if (c <= 20) win_reads++;
            end
            if (out_valid && out_ready) begin
               cap_pix.push_back(out_pix);
               cap_flg.push_back({sof, eol, eof});
               cap_cyc.push_back(c);
            end
            if (done_n > 0 && c == done_cyc + 1) post_busy = busy;
            if (done) begin
               done_n++;
               done_cyc = c;
               done_busy = busy;
            end
            occ_m = occ_m + int'(prev_rd) - int'(out_valid && out_ready);
            if (occ_m > 2 || occ_m < 0) occ_bad++;
            prev_rd = rd_en;
            prev_stall = out_valid && !out_ready;
            prev_beat = {out_pix, sof, eol, eof};
         end
         if ((done_n > 0 && c >= done_cyc + 2) || (rst_at >= 0 && c >= rst_at + 4)) fin = 1'b1;
         step();
      end
      start = 1'b0;
      out_ready = 1'b1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; out_ready = 1'b1; start1 = 1'b0; ready1 = 1'b1;
      step();
      step();
      @(negedge clk);
      total++;
      if ({busy, done, rd_en, out_valid, sof, eol, eof} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {busy, done, rd_en, out_valid, sof, eol, eof});
      end
      total++;
      if ({rd_addr, out_pix} !== 12'h000) begin
         bad++;
         $display("FAIL reset_data: rd_addr=%0d pixel=%0d want 0/0", rd_addr, out_pix);
      end
      total++;
      if ({busy1, done1, rd_en1, valid1, sof1, eol1, eof1, rd_addr1, pix1} !== 16'h0) begin
         bad++;
         $display("FAIL reset_1x1: got %h want 0",
                  {busy1, done1, rd_en1, valid1, sof1, eol1, eof1, rd_addr1, pix1});
      end
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int errs;
      run_frame(0, 1'b0, -1);
      total++;
      if ({c1_busy, c1_rd_en, c1_addr} !== 6'b110000) begin
         bad++;
         $display("FAIL basic_first_read: busy=%b rd_en=%b addr=%0d want 1/1/0",
                  c1_busy, c1_rd_en, c1_addr);
      end
      total++;
      if (cap_pix.size() != 12) begin
         bad++;
         $display("FAIL basic_count: got %0d beats want 12", cap_pix.size());
      end
      errs = 0;
      for (int i = 0; i < cap_pix.size() && i < 12; i++) begin
         if (cap_pix[i] !== 8'(i) || cap_cyc[i] != 3 + i) errs++;
         if (cap_flg[i] !== {i == 0, i % 4 == 3, i == 11}) errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL basic_beats: %0d beat/flag/timing errors want 0", errs);
      end
      total++;
      if (done_n != 1 || done_cyc != 15) begin
         bad++;
         $display("FAIL basic_done: count=%0d cycle=%0d want 1/15", done_n, done_cyc);
      end
      total++;
      if ({done_busy, post_busy} !== 2'b10) begin
         bad++;
         $display("FAIL basic_busy: busy at done=%b after=%b want 1/0", done_busy, post_busy);
      end
      total++;
      if (addr_bad != 0 || occ_bad != 0) begin
         bad++;
         $display("FAIL basic_reads: addr errs=%0d occupancy errs=%0d want 0/0",
                  addr_bad, occ_bad);
      end
   endtask

   task automatic test_backpressure();
      int errs;
      run_frame(1, 1'b0, -1);
      errs = 0;
      for (int i = 0; i < cap_pix.size() && i < 12; i++)
         if (cap_pix[i] !== 8'(i) || cap_flg[i] !== {i == 0, i % 4 == 3, i == 11}) errs++;
      total++;
      if (cap_pix.size() != 12 || errs != 0) begin
         bad++;
         $display("FAIL bp_sequence: beats=%0d errs=%0d want 12/0", cap_pix.size(), errs);
      end
      total++;
      if (stall_bad != 0) begin
         bad++;
         $display("FAIL bp_stable: %0d unstable stall cycles want 0", stall_bad);
      end
      total++;
      if (occ_bad != 0 || addr_bad != 0) begin
         bad++;
         $display("FAIL bp_credit: occupancy errs=%0d addr errs=%0d want 0/0", occ_bad, addr_bad);
      end
      total++;
      if (done_n != 1) begin
         bad++;
         $display("FAIL bp_done: got %0d done pulses want 1", done_n);
      end
   endtask

   task automatic test_restart_ignored();
      int errs;
      run_frame(0, 1'b1, -1);
      errs = 0;
      for (int i = 0; i < cap_pix.size() && i < 12; i++)
         if (cap_pix[i] !== 8'(i)) errs++;
      total++;
      if (cap_pix.size() != 12 || errs != 0) begin
         bad++;
         $display("FAIL restart_beats: beats=%0d errs=%0d want 12/0", cap_pix.size(), errs);
      end
      total++;
      if (done_n != 1 || done_cyc != 15) begin
         bad++;
         $display("FAIL restart_done: count=%0d cycle=%0d want 1/15", done_n, done_cyc);
      end
   endtask

   task automatic test_reset_midframe();
      int errs;
      run_frame(0, 1'b0, 8);
      total++;
      if (snap_rst !== 19'h0) begin
         bad++;
         $display("FAIL midreset_outputs: got %h want 0", snap_rst);
      end
      total++;
      if (cap_pix.size() != 5 || done_n != 0) begin
         bad++;
         $display("FAIL midreset_partial: beats=%0d done=%0d want 5/0", cap_pix.size(), done_n);
      end
      run_frame(0, 1'b0, -1);
      errs = 0;
      for (int i = 0; i < cap_pix.size() && i < 12; i++)
         if (cap_pix[i] !== 8'(i) || cap_cyc[i] != 3 + i) errs++;
      total++;
      if (cap_pix.size() != 12 || errs != 0) begin
         bad++;
         $display("FAIL midreset_fresh: beats=%0d errs=%0d want 12/0", cap_pix.size(), errs);
      end
   endtask

   task automatic test_stall();
      int errs;
      run_frame(2, 1'b0, -1);
      total++;
      if (win_reads != 2) begin
         bad++;
         $display("FAIL stall_reads: got %0d reads while stalled want 2", win_reads);
      end
      total++;
      if (snap_stall !== {1'b1, 8'h00, 1'b1}) begin
         bad++;
         $display("FAIL stall_hold: valid/pixel/sof=%h want 201", snap_stall);
      end
      errs = 0;
      for (int i = 0; i < cap_pix.size() && i < 12; i++)
         if (cap_pix[i] !== 8'(i)) errs++;
      total++;
      if (cap_pix.size() != 12 || errs != 0 || stall_bad != 0) begin
         bad++;
         $display("FAIL stall_release: beats=%0d errs=%0d unstable=%0d want 12/0/0",
                  cap_pix.size(), errs, stall_bad);
      end
   endtask

   task automatic test_single();
      int         n;
      int         beat_c;
      int         done_c;
      int         dn;
      logic [7:0] pix;
      logic [2:0] flg;
      n = 0; beat_c = -1; done_c = -1; dn = 0; pix = '0; flg = '0;
      for (int c = 0; c < 12; c++) begin
         start1 = (c == 0);
         ready1 = 1'b1;
         @(negedge clk);
         if (valid1 && ready1) begin
            n++; beat_c = c; pix = pix1; flg = {sof1, eol1, eof1};
         end
         if (done1) begin
            dn++; done_c = c;
         end
         step();
      end
      start1 = 1'b0;
      total++;
      if (n != 1 || pix !== 8'hA5 || flg !== 3'b111) begin
         bad++;
         $display("FAIL single_beat: beats=%0d pixel=%h flags=%b want 1/a5/111", n, pix, flg);
      end
      total++;
      if (beat_c != 3 || dn != 1 || done_c != 4) begin
         bad++;
         $display("FAIL single_timing: beat cycle=%0d done count=%0d cycle=%0d want 3/1/4",
                  beat_c, dn, done_c);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_restart_ignored();
      test_reset_midframe();
      test_stall();
      test_single();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
